sha256_block_ctrl: RTL and testbench

- Sequencing FSM for the SHA-256 compression datapath under `top`.
- Accepts a start request with a block count and loads the initial hash value.
- For each padded 512-bit block it handshakes the block in, steps the 64 compression rounds, then commits the intermediate hash.
- Signals completion when the last block is folded in. The datapath itself (W registers, K ROM, working variables, H registers) is external; this block only generates the control strobes.

---
 rtl/sha256_block_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_sha256_block_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl
//    Sequencing FSM for an external SHA-256 compression datapath. It takes a
//    start request with a padded block count, loads the IV, then for every
//    block handshakes it in, steps the compression rounds and commits the
//    intermediate hash. A one-cycle done pulse marks the final block.
//
// Ports
//    clk         in   rising-edge system clock
//    reset       in   asynchronous active-high reset
//    start       in   begin hashing (sampled only in IDLE)
//    num_blocks  in   padded block count, latched when start is accepted
//    abort       in   synchronous cancel of the current message
//    blk_valid   in   next padded block is present at the datapath input
//    blk_ready   out  controller accepts a block this cycle
//    init_h      out  load the IV into H
//    load_w      out  capture block into W[0..15] and H into a..h
//    round_en    out  advance the working variables one round
//    round_idx   out  current round t (also the K ROM address)
//    w_from_msg  out  W taken directly from the loaded block
//    update_h    out  H <= H + {a..h}
//    blk_cnt     out  number of blocks already committed
//    busy        out  high in every state except IDLE
//    done        out  one-cycle completion pulse
module sha256_block_ctrl #(
   parameter int NB_W      = 8,
   parameter int ROUNDS    = 64,
   parameter int MSG_WORDS = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [NB_W-1:0] num_blocks,
   input  logic            abort,
   input  logic            blk_valid,
   output logic            blk_ready,
   output logic            init_h,
   output logic            load_w,
   output logic            round_en,
   output logic [5:0]      round_idx,
   output logic            w_from_msg,
   output logic            update_h,
   output logic [NB_W-1:0] blk_cnt,
   output logic            busy,
   output logic            done
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_WAIT   = 3'd2,
      S_ROUND  = 3'd3,
      S_UPDATE = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   localparam logic [NB_W-1:0] CNT_ZERO = {NB_W{1'b0}};
   localparam logic [NB_W-1:0] CNT_ONE  = {{(NB_W-1){1'b0}}, 1'b1};
   localparam logic [5:0]      IDX_LAST = 6'(ROUNDS - 1);
   localparam logic [6:0]      MSG_LIM  = 7'(MSG_WORDS);

   state_t            state_q, state_d;
   logic [NB_W-1:0]   nblk_q, nblk_d;
   logic [NB_W-1:0]   cnt_q, cnt_d;
   logic [NB_W-1:0]   cnt_inc_s;
   logic [5:0]        idx_q, idx_d;
   logic              blk_ready_q, blk_ready_d;
   logic              init_h_q, init_h_d;
   logic              round_en_q, round_en_d;
   logic              w_from_msg_q, w_from_msg_d;
   logic              update_h_q, update_h_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Modulo-2^NB_W increment; the terminal compare uses the latched count,
   // so a full-scale count still terminates.
   assign cnt_inc_s = cnt_q + CNT_ONE;

   // Next-state, counter and next-output decode.
   always_comb begin
      state_d = state_q;
      nblk_d  = nblk_q;
      cnt_d   = cnt_q;
      idx_d   = 6'd0;
      case (state_q)
         S_IDLE: begin
            if (start && (num_blocks != CNT_ZERO)) begin
               nblk_d  = num_blocks;
               state_d = S_INIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_INIT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               cnt_d   = CNT_ZERO;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (blk_valid) begin
               state_d = S_ROUND;
            end else begin
               state_d = S_WAIT;
            end
         end
         S_ROUND: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (idx_q == IDX_LAST) begin
               state_d = S_UPDATE;
            end else begin
               idx_d   = idx_q + 6'd1;
            end
         end
         S_UPDATE: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               cnt_d   = cnt_inc_s;
               state_d = (cnt_inc_s == nblk_q) ? S_DONE : S_WAIT;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they appear registered.
      blk_ready_d  = (state_d == S_WAIT);
      init_h_d     = (state_d == S_INIT);
      round_en_d   = (state_d == S_ROUND);
      w_from_msg_d = (state_d == S_ROUND) && ({1'b0, idx_d} < MSG_LIM);
      update_h_d   = (state_d == S_UPDATE);
      done_d       = (state_d == S_DONE);
      busy_d       = (state_d != S_IDLE);
   end

   // State, counters and registered strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         nblk_q       <= CNT_ZERO;
         cnt_q        <= CNT_ZERO;
         idx_q        <= 6'd0;
         blk_ready_q  <= 1'b0;
         init_h_q     <= 1'b0;
         round_en_q   <= 1'b0;
         w_from_msg_q <= 1'b0;
         update_h_q   <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         nblk_q       <= nblk_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         blk_ready_q  <= blk_ready_d;
         init_h_q     <= init_h_d;
         round_en_q   <= round_en_d;
         w_from_msg_q <= w_from_msg_d;
         update_h_q   <= update_h_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   // The handshake strobe is the only combinational output: a block is
   // captured in the same cycle it is offered, unless abort cancels it.
   assign load_w     = blk_ready_q & blk_valid & ~abort;
   assign blk_ready  = blk_ready_q;
   assign init_h     = init_h_q;
   assign round_en   = round_en_q;
   assign round_idx  = idx_q;
   assign w_from_msg = w_from_msg_q;
   assign update_h   = update_h_q;
   assign blk_cnt    = cnt_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_sha256_block_ctrl.sv
module tb_sha256_block_ctrl;

   localparam int MAXC = 1024;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] num_blocks;
   logic       abort;
   logic       blk_valid;
   logic       blk_ready, init_h, load_w, round_en, w_from_msg, update_h, busy, done;
   logic [5:0] round_idx;
   logic [7:0] blk_cnt;

   sha256_block_ctrl #(.NB_W(8), .ROUNDS(64), .MSG_WORDS(16)) dut (
      .clk(clk), .reset(reset), .start(start), .num_blocks(num_blocks),
      .abort(abort), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .init_h(init_h), .load_w(load_w), .round_en(round_en),
      .round_idx(round_idx), .w_from_msg(w_from_msg), .update_h(update_h),
      .blk_cnt(blk_cnt), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic       busy;
      logic       init_h;
      logic       blk_ready;
      logic       load_w;
      logic       round_en;
      logic [5:0] idx;
      logic       wmsg;
      logic       update_h;
      logic [7:0] cnt;
      logic       done;
   } obs_t;

   // table record: inputs for one cycle and the control strobes expected then
   typedef struct {
      logic       start;
      logic [7:0] nb;
      logic       abort;
      logic       valid;
      logic       e_busy;
      logic       e_init;
      logic       e_ready;
      logic       e_load;
      logic       e_round;
   } vec_t;

   int   n_chk  = 0;
   int   n_pass = 0;
   obs_t exp_a [MAXC];
   obs_t act_a [MAXC];
   logic vld_a [MAXC];
   logic abt_a [MAXC];
   logic [7:0] cnt_model = 8'd0;

   function automatic obs_t get_out();
      obs_t o;
      o.busy = busy; o.init_h = init_h; o.blk_ready = blk_ready; o.load_w = load_w;
      o.round_en = round_en; o.idx = round_idx; o.wmsg = w_from_msg;
      o.update_h = update_h; o.cnt = blk_cnt; o.done = done;
      return o;
   endfunction

   function automatic obs_t idle_o(input logic [7:0] cnt);
      obs_t o;
      o = '0;
      o.cnt = cnt;
      return o;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
   endtask

   // Builds the expected per-cycle trace of one message from the block-level
   // timeline: IV load, then per block (wait, handshake, ROUNDS rounds,
   // commit), then done. Cycle 0 is the cycle in which start is offered.
   // vmode: 0 = blk_valid always 1, 1 = random, 2 = low for 5 cycles before block 2.
   // abort_at: -1 none, 0 random point in a wait/round cycle, >0 fixed cycle.
   task automatic build(input int nblk, input int vmode, input int abort_at, output int last);
      int t;
      int a;
      obs_t o;
      for (int c = 0; c < MAXC; c++) begin
         vld_a[c] = (vmode == 0) ? 1'b1 :
                    (vmode == 1) ? 1'($urandom_range(0, 1)) :
                    !(c >= 68 && c <= 72);
         abt_a[c] = 1'b0;
         exp_a[c] = idle_o(cnt_model);
      end
      o = idle_o(cnt_model); o.busy = 1'b1; o.init_h = 1'b1;
      exp_a[1] = o;
      t = 2;
      for (int b = 0; b < nblk; b++) begin
         while (!vld_a[t]) begin
            o = idle_o(8'(b)); o.busy = 1'b1; o.blk_ready = 1'b1;
            exp_a[t] = o; t++;
            if (t > MAXC - 100) vld_a[t] = 1'b1;
         end
         o = idle_o(8'(b)); o.busy = 1'b1; o.blk_ready = 1'b1; o.load_w = 1'b1;
         exp_a[t] = o; t++;
         for (int r = 0; r < 64; r++) begin
            o = idle_o(8'(b)); o.busy = 1'b1; o.round_en = 1'b1;
            o.idx = 6'(r); o.wmsg = (r < 16);
            exp_a[t] = o; t++;
         end
         o = idle_o(8'(b)); o.busy = 1'b1; o.update_h = 1'b1;
         exp_a[t] = o; t++;
      end
      o = idle_o(8'(nblk)); o.busy = 1'b1; o.done = 1'b1;
      exp_a[t] = o;
      last = t;
      for (int c = t + 1; c < MAXC; c++) exp_a[c] = idle_o(8'(nblk));
      if (abort_at >= 0) begin
         a = abort_at;
         if (a == 0) begin
            a = $urandom_range(2, last - 1);
            while (!(exp_a[a].blk_ready || exp_a[a].round_en)) a = $urandom_range(2, last - 1);
         end
         abt_a[a] = 1'b1;
         exp_a[a].load_w = 1'b0;
         for (int c = a + 1; c < MAXC; c++) exp_a[c] = idle_o(exp_a[a].cnt);
         last = a;
      end
      cnt_model = exp_a[last].cnt;
   endtask

   // Applies the message built above and compares every cycle. Stray start
   // pulses are thrown in while busy; they must be ignored.
   task automatic run(input int nblk, input int last);
      obs_t o;
      for (int c = 0; c <= last + 2; c++) begin
         @(negedge clk);
         start      = (c == 0) ? 1'b1 : ((c <= last) && ($urandom_range(0, 7) == 0));
         num_blocks = (c == 0) ? 8'(nblk) : 8'($urandom_range(0, 255));
         abort      = abt_a[c];
         blk_valid  = vld_a[c];
         #1;
         o = get_out();
         act_a[c] = o;
         check($sformatf("trace[c%0d]", c), 32'(o), 32'(exp_a[c]));
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b0; blk_valid = 1'b0;
   endtask

   vec_t tbl [14];

   initial begin
      int   last;
      int   ups, dones, inits, cyc;
      logic [7:0] got_cnt;

      tbl[0]  = '{0, 8'd0, 0, 0,  0, 0, 0, 0, 0};
      tbl[1]  = '{1, 8'd0, 0, 0,  0, 0, 0, 0, 0};   // zero blocks: ignored
      tbl[2]  = '{0, 8'd0, 0, 1,  0, 0, 0, 0, 0};
      tbl[3]  = '{0, 8'd0, 1, 0,  0, 0, 0, 0, 0};   // abort in IDLE
      tbl[4]  = '{1, 8'd2, 1, 0,  0, 0, 0, 0, 0};   // start wins over abort
      tbl[5]  = '{0, 8'd0, 0, 0,  1, 1, 0, 0, 0};
      tbl[6]  = '{0, 8'd0, 0, 0,  1, 0, 1, 0, 0};
      tbl[7]  = '{0, 8'd0, 1, 1,  1, 0, 1, 0, 0};   // abort suppresses load_w
      tbl[8]  = '{0, 8'd0, 0, 1,  0, 0, 0, 0, 0};
      tbl[9]  = '{1, 8'd1, 0, 1,  0, 0, 0, 0, 0};
      tbl[10] = '{0, 8'd0, 0, 1,  1, 1, 0, 0, 0};
      tbl[11] = '{0, 8'd0, 0, 1,  1, 0, 1, 1, 0};
      tbl[12] = '{0, 8'd0, 1, 0,  1, 0, 0, 0, 1};   // abort in first round
      tbl[13] = '{0, 8'd0, 0, 0,  0, 0, 0, 0, 0};

      reset = 1'b1; start = 1'b0; num_blocks = 8'd0; abort = 1'b0; blk_valid = 1'b0;
      #3;
      check("reset_outputs", 32'(get_out()), 32'd0);
      #17;
      @(negedge clk);
      reset = 1'b0;

      // table-driven IDLE/handshake/abort corner cases
      foreach (tbl[i]) begin
         @(negedge clk);
         start = tbl[i].start; num_blocks = tbl[i].nb;
         abort = tbl[i].abort; blk_valid = tbl[i].valid;
         #1;
         check($sformatf("tbl[%0d]", i),
               {27'd0, busy, init_h, blk_ready, load_w, round_en},
               {27'd0, tbl[i].e_busy, tbl[i].e_init, tbl[i].e_ready, tbl[i].e_load, tbl[i].e_round});
      end
      @(negedge clk);
      start = 1'b0; abort = 1'b0; blk_valid = 1'b0;
      cnt_model = 8'd0;

      // single block, blk_valid held high
      build(1, 0, -1, last);
      run(1, last);
      check("single_init_c1",   32'(act_a[1].init_h),  32'd1);
      check("single_load_c2",   32'(act_a[2].load_w),  32'd1);
      check("single_idx_c3",    32'(act_a[3].idx),     32'd0);
      check("single_idx_c66",   32'(act_a[66].idx),    32'd63);
      check("single_wmsg_c18",  32'(act_a[18].wmsg),   32'd1);
      check("single_wmsg_c19",  32'(act_a[19].wmsg),   32'd0);
      check("single_upd_c67",   32'(act_a[67].update_h), 32'd1);
      check("single_done_c68",  32'(act_a[68].done),   32'd1);
      check("single_busy_c69",  32'(act_a[69].busy),   32'd0);

      // two blocks with a 5-cycle gap before block 2
      build(2, 2, -1, last);
      run(2, last);
      check("two_load_c73",  32'(act_a[73].load_w), 32'd1);
      check("two_done_c139", 32'(act_a[139].done),  32'd1);
      check("two_cnt_done",  32'(act_a[139].cnt),   32'd2);

      // abort at round_idx 30, then a fresh message completes
      build(1, 0, 33, last);
      run(1, last);
      check("abort_idx30", 32'(act_a[33].idx), 32'd30);
      build(1, 0, -1, last);
      run(1, last);
      check("after_abort_done", 32'(act_a[68].done), 32'd1);

      // randomized messages against the block-level model
      for (int m = 0; m < 10; m++) begin
         int nb;
         nb = $urandom_range(1, 3);
         build(nb, 1, ($urandom_range(0, 2) == 0) ? 0 : -1, last);
         run(nb, last);
      end

      // maximum block count, with a stray start while busy
      @(negedge clk);
      start = 1'b1; num_blocks = 8'd255; blk_valid = 1'b1; abort = 1'b0;
      ups = 0; dones = 0; inits = 0; cyc = 0; got_cnt = 8'd0;
      while (dones == 0 && cyc < 20000) begin
         @(negedge clk);
         start = (cyc == 500);
         #1;
         if (update_h) ups++;
         if (init_h) inits++;
         if (done) begin dones++; got_cnt = blk_cnt; end
         cyc++;
      end
      start = 1'b0;
      check("max_done_seen",  32'(dones), 32'd1);
      check("max_done_cycle", 32'(cyc),   32'd16832);
      check("max_updates",    32'(ups),   32'd255);
      check("max_inits",      32'(inits), 32'd1);
      check("max_cnt",        32'(got_cnt), 32'd255);
      @(negedge clk);
      #1;
      check("max_busy_low", 32'(busy), 32'd0);

      // asynchronous reset in the middle of ROUND
      @(negedge clk);
      start = 1'b1; num_blocks = 8'd1; blk_valid = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (12) @(negedge clk);
      #1;
      check("pre_rst_round", 32'(round_en), 32'd1);
      @(posedge clk);
      #3;
      reset = 1'b1;
      #1;
      check("async_rst_outputs", 32'(get_out()), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      repeat (80) begin
         @(negedge clk);
         #1;
         if (done || busy) break;
      end
      check("post_rst_idle", {30'd0, busy, done}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
